// File: rtl/match_pkg.sv
// Shared types and constants for the round/match sequencer.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COUNTDOWN  = 3'd1,
    PLAY       = 3'd2,
    RESULT     = 3'd3,
    MATCH_OVER = 3'd4
  } state_e;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam int SCORE_W = 4;
  localparam int TICK_W  = 10;

endpackage

// File: rtl/match_ctrl_click_edge.sv
// Rising-edge detector for a mouse button level.
// Previous sample resets high so a button held through reset never fires.
module click_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= btn;
  end

  assign rise = btn & ~prev_q;

endmodule

// File: rtl/match_ctrl.sv
// Round and match sequencer: arming, countdown, verdicts, scoring
// and match decision for the two-player game field.
module match_ctrl
  import match_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int CD_STEPS      = 3,
  parameter int STEP_FRAMES   = 60,
  parameter int RESULT_FRAMES = 120
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 click_local,
  input  logic                 click_remote,
  input  logic                 winner_valid,
  input  logic [1:0]           winner_code,
  output logic                 game_rst,
  output logic [2:0]           state_o,
  output logic [3:0]           cd_digit,
  output logic                 ready_l,
  output logic                 ready_r,
  output logic [SCORE_W-1:0]   score_p1,
  output logic [SCORE_W-1:0]   score_p2,
  output logic [1:0]           last_result,
  output logic [1:0]           match_winner
);

  localparam logic [3:0]         CD_INIT  = 4'(CD_STEPS);
  localparam logic [TICK_W-1:0]  STEP_LIM = TICK_W'(STEP_FRAMES);
  localparam logic [TICK_W-1:0]  RES_LIM  = TICK_W'(RESULT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(ROUNDS_TO_WIN);
  localparam logic [SCORE_W-1:0] SAT      = '1;

  logic rise_l, rise_r;

  click_edge u_edge_l (
    .clk  (clk),
    .rst  (rst),
    .btn  (click_local),
    .rise (rise_l)
  );

  click_edge u_edge_r (
    .clk  (clk),
    .rst  (rst),
    .btn  (click_remote),
    .rise (rise_r)
  );

  state_e              state_q, state_d;
  logic [3:0]          cd_q, cd_d;
  logic                rl_q, rl_d, rr_q, rr_d;
  logic [SCORE_W-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic [1:0]          last_q, last_d, mw_q, mw_d;
  logic                grst_q, grst_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                step;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    rl_d    = rl_q;
    rr_d    = rr_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    last_d  = last_q;
    mw_d    = mw_q;
    step    = 1'b0;
    cnt_inc = cnt_q + 1'b1;

    unique case (state_q)
      IDLE, MATCH_OVER: begin
        rl_d = rl_q | rise_l;
        rr_d = rr_q | rise_r;
        if (rl_d && rr_d) begin
          state_d = COUNTDOWN;
          cd_d    = CD_INIT;
          rl_d    = 1'b0;
          rr_d    = 1'b0;
          if (state_q == MATCH_OVER) begin
            s1_d   = '0;
            s2_d   = '0;
            last_d = RES_NONE;
            mw_d   = RES_NONE;
          end
        end
      end
      COUNTDOWN: begin
        if (frame_tick && cnt_inc == STEP_LIM) begin
          step = 1'b1;
          cd_d = cd_q - 1'b1;
          if (cd_q == 4'd1) state_d = PLAY;
        end
      end
      PLAY: begin
        if (winner_valid) begin
          last_d  = winner_code;
          state_d = RESULT;
          if (winner_code == RES_P1 && s1_q != SAT)
            s1_d = s1_q + 1'b1;
          if (winner_code == RES_P2 && s2_q != SAT)
            s2_d = s2_q + 1'b1;
        end
      end
      RESULT: begin
        if (frame_tick && cnt_inc == RES_LIM) begin
          step = 1'b1;
          if (s1_q == WIN) begin
            state_d = MATCH_OVER;
            mw_d    = RES_P1;
          end else if (s2_q == WIN) begin
            state_d = MATCH_OVER;
            mw_d    = RES_P2;
          end else begin
            state_d = COUNTDOWN;
            cd_d    = CD_INIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on any entry or digit step; ticks then ignored.
    if (state_d != state_q || step)
      cnt_d = '0;
    else if (frame_tick &&
             (state_q == COUNTDOWN || state_q == RESULT))
      cnt_d = cnt_inc;
    else
      cnt_d = cnt_q;

    grst_d = !(state_d == PLAY || state_d == RESULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      rl_q    <= 1'b0;
      rr_q    <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      last_q  <= RES_NONE;
      mw_q    <= RES_NONE;
      grst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      rl_q    <= rl_d;
      rr_q    <= rr_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      last_q  <= last_d;
      mw_q    <= mw_d;
      grst_q  <= grst_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign game_rst     = grst_q;
  assign state_o      = state_q;
  assign cd_digit     = cd_q;
  assign ready_l      = rl_q;
  assign ready_r      = rr_q;
  assign score_p1     = s1_q;
  assign score_p2     = s2_q;
  assign last_result  = last_q;
  assign match_winner = mw_q;

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Round and match sequencer for the two-player game field. Arms a round when both players click, drives `game_rst` to hold the field during a frame-counted countdown, and releases it for play. Consumes the one-cycle winner verdict from the game field, keeps per-player scores and declares the match winner once a player reaches the round target. Sits between the mouse/link inputs and the game-field renderer, clocked by the pixel clock.

## Interface
- `ROUNDS_TO_WIN`, 3: rounds needed to win the match, 1..15.
- `CD_STEPS`, 3: countdown digits shown, 1..15.
- `STEP_FRAMES`, 60: frames per countdown digit, 1..1023.
- `RESULT_FRAMES`, 120: frames the round result is held, 1..1023.

- `clk` in 1: pixel clock, the only clock.
- `rst` in 1: asynchronous reset, active-high.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `click_local` in 1: local left mouse button, level.
- `click_remote` in 1: remote left mouse button, level.
- `winner_valid` in 1: one-cycle verdict strobe from the game field.
- `winner_code` in 2: 01 = P1 wins, 10 = P2 wins, 11 = draw. Sampled only with `winner_valid`.
- `game_rst` out 1: synchronous hold/reset level to the game field.
- `state_o` out 3: current state encoding.
- `cd_digit` out 4: countdown digit to display. 0 outside COUNTDOWN.
- `ready_l`, `ready_r` out 1: player has armed.
- `score_p1`, `score_p2` out 4: rounds won.
- `last_result` out 2: code of the last accepted verdict.
- `match_winner` out 2: 01 or 10 once the match is decided, else 00.

## Operation
- **Click edges:** one edge detector per button. The previous-sample register resets to 1, so a button held through reset does not count. Only rising edges count.
- **IDLE:**
  - `game_rst`=1.
  - A local edge sets `ready_l`; a remote edge sets `ready_r`.
  - When both are set, go to COUNTDOWN. Same-cycle edges on both buttons qualify.
- **COUNTDOWN:**
  - `game_rst`=1; ready flags cleared.
  - `cd_digit` loads `CD_STEPS` on entry.
  - Every `STEP_FRAMES` ticks, `cd_digit` decrements.
  - A decrement from 1 goes to PLAY with `cd_digit`=0.
- **PLAY:**
  - `game_rst`=0.
  - On `winner_valid`: latch `last_result` and go to RESULT.
  - Score update on the same edge: code 01 increments `score_p1`; 10 increments `score_p2`; 11 and illegal 00 change neither.
  - Scores saturate at 15.
- **RESULT:**
  - `game_rst`=0, so the field keeps running; further `winner_valid` is ignored.
  - After `RESULT_FRAMES` ticks: if either score equals `ROUNDS_TO_WIN`, go to MATCH_OVER and set `match_winner` to that player; else go to COUNTDOWN.
- **MATCH_OVER:**
  - `game_rst`=1; ready flags arm as in IDLE.
  - When both are armed, clear scores, `last_result` and `match_winner`, then go to COUNTDOWN.
- **Ignored events:** `winner_valid` outside PLAY and clicks outside IDLE/MATCH_OVER are ignored.

## Timing
- **Registered outputs:** all outputs are registered. A state change is visible one cycle after the causing edge/pulse.
- **Reset values:**
  - State IDLE, `game_rst`=1.
  - All flags, scores, `cd_digit`, `last_result`, `match_winner` = 0.
  - Tick counter = 0.
- **Tick counter:**
  - 10 bits, cleared on every state entry and on each `cd_digit` step.
  - A `frame_tick` in the entry cycle is not counted.
  - A step fires on the tick that brings the count to the limit, which is `STEP_FRAMES` or `RESULT_FRAMES`.
- **COUNTDOWN length:** exactly `CD_STEPS`×`STEP_FRAMES` ticks before PLAY.
- **`game_rst` at round boundaries:**
  - Falls in the same cycle `state_o` shows PLAY.
  - Rises in the same cycle RESULT exits to COUNTDOWN or MATCH_OVER, giving the field at least `CD_STEPS`×`STEP_FRAMES` frames of reset.
- **`winner_valid` vs RESULT:** `winner_valid` in the PLAY-entry cycle is accepted.
- **Reset mid-round:** asynchronous `rst` returns to IDLE immediately from any state, with scores lost.

## Structure
- **Package `match_pkg`:**
  - `state_e` enum with values IDLE=0, COUNTDOWN=1, PLAY=2, RESULT=3, MATCH_OVER=4.
  - Result constants `RES_NONE` 00, `RES_P1` 01, `RES_P2` 10, `RES_DRAW` 11.
  - Score width constant 4.
- **Sub-module `click_edge`:** one flop plus AND, reset value 1. Instantiated twice.
- **Top:** one FSM `always_ff` plus a tick counter.

## Test plan
Bench parameters: `ROUNDS_TO_WIN`=2, `CD_STEPS`=3, `STEP_FRAMES`=2, `RESULT_FRAMES`=3.

1. **Arming:** local click, then remote click 10 cycles later.
   - Required: `ready_l`=1 after the first edge; COUNTDOWN with `cd_digit`=3 after the second.
   - Required: 3,2,1 each lasting 2 ticks; PLAY and `game_rst`=0 after the 6th tick.
2. **Verdict acceptance:** in PLAY, pulse `winner_valid` with 01.
   - Required: `score_p1`=1, `last_result`=01, RESULT.
   - Required: after 3 ticks, COUNTDOWN with `game_rst`=1.
3. **Match end:** P2 wins two rounds (10, 10).
   - Required: MATCH_OVER, `match_winner`=10, `score_p2`=2.
   - Required: a double click returns to COUNTDOWN with scores 0.
4. **Draw and spurious verdicts:** draw (11) in PLAY, plus a `winner_valid` pulse in RESULT and in COUNTDOWN.
   - Required: scores unchanged, `last_result`=11, no extra state change.
5. **Held button and simultaneous clicks:** button held through `rst` release.
   - Required: not armed.
   - Required: a release then simultaneous edges on both buttons arm in one cycle.
6. **Reset mid-round:** `rst` asserted during PLAY with score 1:0.
   - Required: immediate IDLE, `game_rst`=1, scores 0, `match_winner`=00.
